// File: rtl/event_encoder_8to3.sv
// Collects events on eight request lines into a pending register and serves them
// one at a time as a registered 3-bit code with a valid/ready handshake.
module event_encoder_8to3 #(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       out_ready,
  input  logic       ovf_clr,
  output logic       out_valid,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       out_multi,
  output logic [7:0] pending,
  output logic       ovf
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  logic       state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pending_q, pending_d;
  logic       multi_q, multi_d;
  logic       ovf_q, ovf_d;

  logic [7:0] e;
  logic [7:0] e_rest;
  logic [2:0] sel;
  logic       slot_free;
  logic       ovf_set;

  assign e         = pending_q | d;
  assign slot_free = (state_q == ST_EMPTY) | out_ready;

  // Priority pick over the merged request vector; the last match in loop order wins.
  always_comb begin
    sel = 3'd0;
    if (HI_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (e[i]) sel = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (e[i]) sel = 3'(i);
    end
  end

  assign e_rest = e & ~(8'b1 << sel);

  // A repeat on a pending line, or on the line whose code is stalled at the output.
  assign ovf_set = (|(d & pending_q)) |
                   ((state_q == ST_HOLD) & ~out_ready & d[code_q]);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pending_d = pending_q;
    multi_d   = multi_q;
    ovf_d     = ovf_set | (ovf_q & ~ovf_clr);
    if (slot_free) begin
      if (|e) begin
        state_d   = ST_HOLD;
        code_d    = sel;
        pending_d = e_rest;
        multi_d   = |e_rest;
      end else begin
        state_d   = ST_EMPTY;
        pending_d = 8'h00;
        multi_d   = 1'b0;
      end
    end else begin
      pending_d = pending_q | d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      code_q    <= 3'd0;
      pending_q <= 8'h00;
      multi_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      multi_q   <= multi_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = state_q;
  assign x         = code_q[2];
  assign y         = code_q[1];
  assign z         = code_q[0];
  assign out_multi = multi_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Bench for event_encoder_8to3: directed vector table, hand-written corner sequences,
// and random traffic compared against a behavioural model, for both priority orders.
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = 8'h00;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [1:0] vld, xo, yo, zo, mul, ovo;
  logic [7:0] pend [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0 serves highest index first, instance 1 lowest index first.
  event_encoder_8to3 #(.HI_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .d(d), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(vld[0]), .x(xo[0]), .y(yo[0]), .z(zo[0]), .out_multi(mul[0]),
    .pending(pend[0]), .ovf(ovo[0]));

  event_encoder_8to3 #(.HI_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .d(d), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(vld[1]), .x(xo[1]), .y(yo[1]), .z(zo[1]), .out_multi(mul[1]),
    .pending(pend[1]), .ovf(ovo[1]));

  // Behavioural model state, one slot per instance.
  logic [7:0] mp [2];
  logic       mv [2];
  int         mc [2];
  logic       mm [2];
  logic       mo [2];

  function automatic int pick(input logic [7:0] ev, input bit hi);
    int r = 0;
    if (hi) begin
      for (int i = 0; i < 8; i++) if (ev[i]) r = i;
    end else begin
      for (int i = 7; i >= 0; i--) if (ev[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic [2:0] code_of(input int k);
    return {xo[k], yo[k], zo[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mp[k] = 8'h00; mv[k] = 1'b0; mc[k] = 0; mm[k] = 1'b0; mo[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] ev;
      logic       set;
      int         p;
      ev  = mp[k] | d;
      set = (|(d & mp[k])) || (mv[k] && !out_ready && d[mc[k]]);
      mo[k] = set | (mo[k] & ~ovf_clr);
      if (!mv[k] || out_ready) begin
        if (ev != 8'h00) begin
          p = pick(ev, k == 0);
          mc[k] = p;
          mv[k] = 1'b1;
          mp[k] = ev & ~(8'h01 << p);
          mm[k] = (mp[k] != 8'h00);
        end else begin
          mv[k] = 1'b0; mp[k] = 8'h00; mm[k] = 1'b0;
        end
      end else begin
        mp[k] = mp[k] | d;
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic cycle(input logic [7:0] dv, input logic rdy, input logic clr);
    d = dv; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; d = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all(input string name, input int k, input logic v, input logic [2:0] c,
                         input logic m, input logic [7:0] p, input logic o);
    chk({name, ".valid"}, 8'(vld[k]), 8'(v));
    chk({name, ".code"},  8'(code_of(k)), 8'(c));
    chk({name, ".multi"}, 8'(mul[k]), 8'(m));
    chk({name, ".pend"},  pend[k], p);
    chk({name, ".ovf"},   8'(ovo[k]), 8'(o));
  endtask

  typedef struct {
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [2:0] ec;
    logic       em;
    logic [7:0] ep;
    logic       eo;
  } vec_t;

  vec_t tbl [17];

  initial begin
    model_reset();

    tbl[0]  = '{8'h20, 1, 0, 1, 3'd5, 0, 8'h00, 0};
    tbl[1]  = '{8'h00, 1, 0, 0, 3'd5, 0, 8'h00, 0};
    tbl[2]  = '{8'h96, 1, 0, 1, 3'd7, 1, 8'h16, 0};
    tbl[3]  = '{8'h00, 1, 0, 1, 3'd4, 1, 8'h06, 0};
    tbl[4]  = '{8'h00, 1, 0, 1, 3'd2, 1, 8'h02, 0};
    tbl[5]  = '{8'h00, 1, 0, 1, 3'd1, 0, 8'h00, 0};
    tbl[6]  = '{8'h00, 1, 0, 0, 3'd1, 0, 8'h00, 0};
    tbl[7]  = '{8'h08, 0, 0, 1, 3'd3, 0, 8'h00, 0};
    tbl[8]  = '{8'h01, 0, 0, 1, 3'd3, 0, 8'h01, 0};
    tbl[9]  = '{8'h00, 0, 0, 1, 3'd3, 0, 8'h01, 0};
    tbl[10] = '{8'h00, 0, 0, 1, 3'd3, 0, 8'h01, 0};
    tbl[11] = '{8'h00, 0, 0, 1, 3'd3, 0, 8'h01, 0};
    tbl[12] = '{8'h00, 0, 0, 1, 3'd3, 0, 8'h01, 0};
    tbl[13] = '{8'h00, 1, 0, 1, 3'd0, 0, 8'h00, 0};
    tbl[14] = '{8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0};
    tbl[15] = '{8'h00, 0, 1, 0, 3'd0, 0, 8'h00, 0};
    tbl[16] = '{8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0};

    // Reset held with all lines requesting: outputs stay cleared, then highest code first.
    @(negedge clk);
    rst_n = 1'b0; d = 8'hFF; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all("rst_hold", 0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    chk_all("rst_hold_lo", 1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    cycle(8'hFF, 1'b1, 1'b0);
    chk_all("rst_first", 0, 1'b1, 3'd7, 1'b1, 8'h7F, 1'b0);
    chk_all("rst_first_lo", 1, 1'b1, 3'd0, 1'b1, 8'hFE, 1'b0);

    // Directed vectors: single pulse, burst, stall with pending pulse.
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk_all($sformatf("tbl%0d", i), 0, tbl[i].ev, tbl[i].ec, tbl[i].em, tbl[i].ep, tbl[i].eo);
    end

    // Merge into a pending line, then set/clear collision on the in-flight line.
    do_reset();
    cycle(8'h0C, 1'b0, 1'b0);
    chk_all("ovf_load", 0, 1'b1, 3'd3, 1'b1, 8'h04, 1'b0);
    cycle(8'h04, 1'b0, 1'b0);
    chk_all("ovf_merge", 0, 1'b1, 3'd3, 1'b1, 8'h04, 1'b1);
    cycle(8'h00, 1'b1, 1'b0);
    chk_all("ovf_serve2", 0, 1'b1, 3'd2, 1'b0, 8'h00, 1'b1);
    cycle(8'h04, 1'b0, 1'b1);
    chk_all("ovf_setwins", 0, 1'b1, 3'd2, 1'b0, 8'h04, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    chk_all("ovf_clr", 0, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    chk_all("ovf_drain", 0, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0);

    // Lowest-first burst, then asynchronous reset in the middle of it.
    do_reset();
    cycle(8'h96, 1'b1, 1'b0);
    chk_all("lo_b0", 1, 1'b1, 3'd1, 1'b1, 8'h94, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    chk_all("lo_b1", 1, 1'b1, 3'd2, 1'b1, 8'h90, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    chk_all("lo_b2", 1, 1'b1, 3'd4, 1'b1, 8'h80, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst.valid", 8'(vld[1]), 8'h00);
    chk("async_rst.pend", pend[1], 8'h00);
    chk("async_rst.code", 8'(code_of(1)), 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model, both priority orders.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] dv;
      dv = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      cycle(dv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d_%0d.valid", n, k), 8'(vld[k]), 8'(mv[k]));
        chk($sformatf("rnd%0d_%0d.code", n, k), 8'(code_of(k)), 8'(mc[k]));
        chk($sformatf("rnd%0d_%0d.multi", n, k), 8'(mul[k]), 8'(mm[k]));
        chk($sformatf("rnd%0d_%0d.pend", n, k), pend[k], mp[k]);
        chk($sformatf("rnd%0d_%0d.ovf", n, k), 8'(ovo[k]), 8'(mo[k]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
